// File: rtl/surf_train_pkg.sv
// Shared types and helpers for the SURF link-training sequencer.
// Optional feature macro used by the top: SURF_TRAIN_ABORT_EN.
package surf_train_pkg;

    localparam int NUM_SLOTS = 7;

    localparam logic [5:0] CTRL_OFFSET_DEF   = 6'h00;
    localparam logic [5:0] STATUS_OFFSET_DEF = 6'h04;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_ARM,
        S_GAP,
        S_POLL,
        S_DISARM,
        S_NEXT,
        S_DONE
    } state_t;

    // SURF n lives in splitter slot n+1; slot 0 belongs to the splitter itself.
    function automatic logic [11:0] slot_adr(input logic [2:0] slot, input logic [5:0] offset);
        logic [2:0] wb_slot;
        wb_slot = slot + 3'd1;
        return {1'b0, wb_slot, offset};
    endfunction

endpackage

// File: rtl/surf_train_wbm.sv
// Single-outstanding Wishbone master: latches a request, holds the bus until ack/err.
module surf_train_wbm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        req_we,
    input  logic [11:0] req_adr,
    input  logic [31:0] req_dat,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        cyc,
    output logic        stb,
    output logic        we,
    output logic [11:0] adr,
    output logic [31:0] dat,
    output logic [3:0]  sel,
    input  logic        ack,
    input  logic        bus_err,
    input  logic [31:0] rd_dat
);

    // Completion wins over a new request, so a caller that keeps req high
    // through the ack cycle never gets a duplicate transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc <= 1'b0;
            we  <= 1'b0;
            adr <= '0;
            dat <= '0;
        end else if (cyc) begin
            if (ack || bus_err) cyc <= 1'b0;
        end else if (req) begin
            cyc <= 1'b1;
            we  <= req_we;
            adr <= req_adr;
            dat <= req_dat;
        end
    end

    assign stb   = cyc;
    assign sel   = 4'hF;
    assign done  = cyc && (ack || bus_err);
    assign err   = cyc && bus_err;
    assign rdata = rd_dat;

endmodule

// File: rtl/surf_train_sequencer.sv
// Trains each enabled SURF link in turn over Wishbone and reports locked/failed masks.
// Define SURF_TRAIN_ABORT_EN to add the abort_i input and the abort path.
module surf_train_sequencer
    import surf_train_pkg::*;
#(
    parameter logic [5:0] CTRL_OFFSET   = CTRL_OFFSET_DEF,
    parameter logic [5:0] STATUS_OFFSET = STATUS_OFFSET_DEF,
    parameter int         TRAIN_BIT     = 0,
    parameter int         LOCK_BIT      = 0,
    parameter int         POLL_GAP      = 255,
    parameter int         MAX_POLLS     = 1023
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        start_i,
    input  logic [6:0]  slot_mask_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [6:0]  locked_o,
    output logic [6:0]  failed_o,
    output logic        aborted_o,
`ifdef SURF_TRAIN_ABORT_EN
    input  logic        abort_i,
`endif
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [11:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    localparam state_t AFTER_ARM = (POLL_GAP == 0) ? S_POLL : S_GAP;

    state_t      state, state_nxt;
    logic [2:0]  slot, scan_slot;
    logic [6:0]  mask;
    logic [9:0]  poll_cnt;
    logic [7:0]  gap_cnt;
    logic        scan_hit, abort_seen;
    logic        set_lock, set_fail, poll_inc;
    logic        req, req_we;
    logic [11:0] req_adr;
    logic [31:0] req_dat;
    logic        wb_done, wb_err;
    logic [31:0] wb_rdata;
    logic        lock_seen;

    surf_train_wbm u_wbm (
        .clk(wb_clk_i), .rst_n(wb_rst_ni),
        .req(req), .req_we(req_we), .req_adr(req_adr), .req_dat(req_dat),
        .done(wb_done), .err(wb_err), .rdata(wb_rdata),
        .cyc(wbm_cyc_o), .stb(wbm_stb_o), .we(wbm_we_o), .adr(wbm_adr_o),
        .dat(wbm_dat_o), .sel(wbm_sel_o),
        .ack(wbm_ack_i), .bus_err(wbm_err_i), .rd_dat(wbm_dat_i)
    );

    assign lock_seen = |(wb_rdata & (32'd1 << LOCK_BIT));

`ifdef SURF_TRAIN_ABORT_EN
    logic abort_q;
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            abort_q   <= 1'b0;
            aborted_o <= 1'b0;
        end else if (state == S_IDLE && start_i) begin
            abort_q   <= 1'b0;
            aborted_o <= 1'b0;
        end else begin
            if (busy_o && abort_i) abort_q <= 1'b1;
            if (state == S_DONE)   aborted_o <= abort_q;
        end
    end
    assign abort_seen = abort_q || (busy_o && abort_i);
`else
    assign abort_seen = 1'b0;
    assign aborted_o  = 1'b0;
`endif

    // Lowest enabled slot at or above the current one.
    always_comb begin
        scan_hit  = 1'b0;
        scan_slot = slot;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(slot))) begin
                scan_hit  = 1'b1;
                scan_slot = 3'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        req_we    = 1'b0;
        req_adr   = slot_adr(slot, CTRL_OFFSET);
        req_dat   = '0;
        set_lock  = 1'b0;
        set_fail  = 1'b0;
        poll_inc  = 1'b0;
        case (state)
            S_IDLE: if (start_i) state_nxt = S_SCAN;
            S_SCAN: state_nxt = (scan_hit && !abort_seen) ? S_ARM : S_DONE;
            S_ARM: begin
                req     = 1'b1;
                req_we  = 1'b1;
                req_dat = 32'd1 << TRAIN_BIT;
                if (wb_done) begin
                    if (wb_err) begin
                        set_fail  = !abort_seen;
                        state_nxt = S_NEXT;
                    end else begin
                        state_nxt = abort_seen ? S_DISARM : AFTER_ARM;
                    end
                end
            end
            S_GAP: begin
                if (abort_seen)                        state_nxt = S_DISARM;
                else if (gap_cnt == 8'(POLL_GAP - 1)) state_nxt = S_POLL;
            end
            S_POLL: begin
                req     = 1'b1;
                req_adr = slot_adr(slot, STATUS_OFFSET);
                if (wb_done) begin
                    state_nxt = S_DISARM;
                    // An aborted slot is left unmarked whatever the read returned.
                    if (abort_seen)                             state_nxt = S_DISARM;
                    else if (wb_err || (!lock_seen && poll_cnt == 10'(MAX_POLLS - 1)))
                                                                set_fail  = 1'b1;
                    else if (lock_seen)                         set_lock  = 1'b1;
                    else begin
                        poll_inc  = 1'b1;
                        state_nxt = AFTER_ARM;
                    end
                end
            end
            S_DISARM: begin
                req    = 1'b1;
                req_we = 1'b1;
                if (wb_done) state_nxt = S_NEXT;
            end
            S_NEXT:  state_nxt = S_SCAN;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            slot     <= '0;
            mask     <= '0;
            locked_o <= '0;
            failed_o <= '0;
            poll_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (state == S_IDLE && start_i) begin
                slot     <= '0;
                mask     <= slot_mask_i;
                locked_o <= '0;
                failed_o <= '0;
            end
            if (state == S_SCAN) slot <= scan_slot;
            if (state == S_NEXT) slot <= slot + 3'd1;
            if (set_lock) locked_o[slot] <= 1'b1;
            if (set_fail) failed_o[slot] <= 1'b1;
            if (state == S_ARM) poll_cnt <= '0;
            else if (poll_inc)  poll_cnt <= poll_cnt + 10'd1;
            gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'd0;
        end
    end

    assign busy_o = (state != S_IDLE) && (state != S_DONE);
    assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_surf_train_sequencer.sv
// Directed bench for surf_train_sequencer with a behavioural Wishbone slave model.
// Build with SURF_TRAIN_ABORT_EN defined to also exercise the abort path.
module tb_surf_train_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [6:0]  slot_mask = '0;
    logic        abort = 1'b0;
    logic        busy, done, aborted;
    logic [6:0]  locked, failed;
    logic        cyc, stb, we;
    logic [11:0] adr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic [31:0] rdat;
    logic        ack, berr;

    always #5 clk = ~clk;

    surf_train_sequencer #(.POLL_GAP(2), .MAX_POLLS(4)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .slot_mask_i(slot_mask),
        .busy_o(busy), .done_o(done), .locked_o(locked), .failed_o(failed),
        .aborted_o(aborted),
`ifdef SURF_TRAIN_ABORT_EN
        .abort_i(abort),
`endif
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_we_o(we), .wbm_adr_o(adr),
        .wbm_dat_o(wdat), .wbm_sel_o(sel), .wbm_dat_i(rdat),
        .wbm_ack_i(ack), .wbm_err_i(berr)
    );

    // Slave model: responds one cycle after cyc, logs every completed transaction.
    int          lock_after [7];
    bit          err_arm [7];
    logic        clr = 1'b0;
    logic [11:0] tx_adr [64];
    logic        tx_we [64];
    logic [31:0] tx_dat [64];
    int          n_tx, done_cnt, max_slot;
    int          rd_cnt [7];

    logic [2:0] cur_s;
    logic       is_arm, is_stat;
    assign cur_s   = adr[8:6] - 3'd1;
    assign is_arm  = we && adr[5:0] == 6'h00 && wdat == 32'd1;
    assign is_stat = !we && adr[5:0] == 6'h04;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack  <= 1'b0;
            berr <= 1'b0;
            rdat <= '0;
        end else begin
            ack  <= 1'b0;
            berr <= 1'b0;
            if (clr) begin
                n_tx     <= 0;
                done_cnt <= 0;
                max_slot <= 0;
                for (int i = 0; i < 7; i++) rd_cnt[i] <= 0;
            end else begin
                if (done) done_cnt <= done_cnt + 1;
                if (cyc && (ack || berr)) begin
                    if (n_tx < 64) begin
                        tx_adr[n_tx] <= adr;
                        tx_we[n_tx]  <= we;
                        tx_dat[n_tx] <= wdat;
                    end
                    n_tx <= n_tx + 1;
                    if (int'(adr[8:6]) > max_slot) max_slot <= int'(adr[8:6]);
                end else if (cyc && stb) begin
                    if (is_arm && err_arm[cur_s]) berr <= 1'b1;
                    else                          ack  <= 1'b1;
                    rdat <= '0;
                    if (is_stat) begin
                        rd_cnt[cur_s] <= rd_cnt[cur_s] + 1;
                        if (lock_after[cur_s] != 0 && rd_cnt[cur_s] + 1 >= lock_after[cur_s])
                            rdat <= 32'd1;
                    end
                end
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clears the slave log and loads a fresh response policy.
    task automatic setup(input int lk, input logic [6:0] errs);
        for (int i = 0; i < 7; i++) begin
            lock_after[i] = lk;
            err_arm[i]    = errs[i];
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic pulse_start(input logic [6:0] m);
        slot_mask = m;
        start     = 1'b1;
        tick(1);
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 2000 && !done; k++) tick(1);
        chk({tag, "_done_seen"}, done, 1'b1);
        tick(2);
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin
            lock_after[i] = 0;
            err_arm[i]    = 1'b0;
        end
        n_tx = 0; done_cnt = 0; max_slot = 0;
        for (int i = 0; i < 7; i++) rd_cnt[i] = 0;
        tick(3);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_locked", locked, 7'h00);
        chk("rst_failed", failed, 7'h00);
        chk("rst_cyc", {cyc, stb, we}, 3'b000);
        chk("rst_adr", adr, 12'h000);
        chk("rst_aborted", aborted, 1'b0);
        rst_n = 1'b1;
        tick(2);

        // single slot, locks on 3rd status read
        setup(3, 7'h00);
        pulse_start(7'h01);
        chk("t1_busy", busy, 1'b1);
        wait_done("t1");
        chk("t1_ntx", n_tx, 5);
        chk("t1_arm", {tx_we[0], tx_adr[0], tx_dat[0]}, {1'b1, 12'h040, 32'h1});
        chk("t1_rd", {tx_we[1], tx_adr[1]}, {1'b0, 12'h044});
        chk("t1_reads", rd_cnt[0], 3);
        chk("t1_disarm", {tx_we[4], tx_adr[4], tx_dat[4]}, {1'b1, 12'h040, 32'h0});
        chk("t1_masks", {locked, failed}, {7'h01, 7'h00});
        chk("t1_aborted", aborted, 1'b0);
        chk("t1_idle", {busy, cyc}, 2'b00);

        // all slots, lock on first read; a second start mid-pass must be ignored
        setup(1, 7'h00);
        pulse_start(7'h7F);
        tick(6);
        pulse_start(7'h00);
        wait_done("t2");
        tick(3);
        chk("t2_ntx", n_tx, 21);
        for (int s = 0; s < 7; s++) begin
            chk($sformatf("t2_arm%0d", s + 1), tx_adr[3*s], 12'((s + 1) << 6));
            chk($sformatf("t2_rd%0d", s + 1), tx_adr[3*s+1], 12'(((s + 1) << 6) | 4));
        end
        chk("t2_masks", {locked, failed}, {7'h7F, 7'h00});
        chk("t2_done_cnt", done_cnt, 1);

        // never locks: exactly MAX_POLLS reads then disarm
        setup(0, 7'h00);
        pulse_start(7'h04);
        wait_done("t3");
        chk("t3_reads", rd_cnt[2], 4);
        chk("t3_ntx", n_tx, 6);
        chk("t3_rd_adr", tx_adr[4], 12'h0C4);
        chk("t3_disarm", {tx_we[5], tx_adr[5], tx_dat[5]}, {1'b1, 12'h0C0, 32'h0});
        chk("t3_masks", {locked, failed}, {7'h00, 7'h04});

        // error on ARM write: failed, no poll or disarm
        setup(1, 7'h02);
        pulse_start(7'h02);
        wait_done("t4");
        chk("t4_ntx", n_tx, 1);
        chk("t4_adr", tx_adr[0], 12'h080);
        chk("t4_masks", {locked, failed}, {7'h00, 7'h02});

        // empty mask: done_o two cycles after start, no bus activity
        setup(1, 7'h00);
        pulse_start(7'h00);
        tick(1);
        chk("t5_done_2cyc", done, 1'b1);
        tick(4);
        chk("t5_ntx", n_tx, 0);
        chk("t5_done_cnt", done_cnt, 1);
        chk("t5_masks", {locked, failed}, {7'h00, 7'h00});

`ifdef SURF_TRAIN_ABORT_EN
        // abort while polling SURF 3: read finishes, disarm 0x100, nothing later
        setup(1, 7'h00);
        lock_after[3] = 0;
        pulse_start(7'h7F);
        for (int k = 0; k < 500 && !(cyc && !we && adr == 12'h104); k++) tick(1);
        abort = 1'b1;
        wait_done("ta");
        abort = 1'b0;
        chk("ta_aborted", aborted, 1'b1);
        chk("ta_last", {tx_we[n_tx-1], tx_adr[n_tx-1], tx_dat[n_tx-1]}, {1'b1, 12'h100, 32'h0});
        chk("ta_max_slot", max_slot, 4);
        chk("ta_masks", {locked, failed}, {7'h07, 7'h00});
`endif

        // reset in the middle of a status read
        setup(0, 7'h00);
        pulse_start(7'h01);
        for (int k = 0; k < 200 && !(cyc && !we); k++) tick(1);
        chk("t7_in_read", {cyc, we}, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("t7_drop", {cyc, stb, busy}, 3'b000);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        setup(2, 7'h00);
        pulse_start(7'h01);
        wait_done("t7");
        chk("t7_ntx", n_tx, 4);
        chk("t7_first", {tx_we[0], tx_adr[0], tx_dat[0]}, {1'b1, 12'h040, 32'h1});
        chk("t7_masks", {locked, failed}, {7'h01, 7'h00});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
